// File: rtl/poolb_ctrl_u3_pkg.sv
// poolb_ctrl_u3_pkg
// Shared definitions for the pooling-datapath controllers.
// Contents:
//   pool_state_t    - controller state encoding (IDLE/RUN/DRAIN/DONE)
//   cnt_width()     - counter width for a modulus, never narrower than 1 bit
//   row_pairs(), groups(), beats_per_layer() - layer geometry helpers
//   DEF_* / ROW_PAIRS / GROUPS / BEATS_PER_LAYER / *_W - default geometry
package poolb_ctrl_u3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_t;

    // A modulus of 1 still needs a 1-bit counter so port vectors stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int row_pairs(input int ifm_size);
        return ifm_size / 2;
    endfunction

    function automatic int groups(input int ifm_depth, input int num_units);
        return ifm_depth / num_units;
    endfunction

    function automatic int beats_per_layer(input int ifm_size, input int ifm_depth,
                                           input int num_units);
        return ifm_size * row_pairs(ifm_size) * groups(ifm_depth, num_units);
    endfunction

    localparam int DEF_IFM_SIZE     = 10;
    localparam int DEF_IFM_DEPTH    = 30;
    localparam int DEF_NUM_UNITS    = 3;
    localparam int DEF_KERNAL_SIZE  = 2;
    localparam int DEF_POOL_LATENCY = 1;

    localparam int ROW_PAIRS       = row_pairs(DEF_IFM_SIZE);
    localparam int GROUPS          = groups(DEF_IFM_DEPTH, DEF_NUM_UNITS);
    localparam int BEATS_PER_LAYER = beats_per_layer(DEF_IFM_SIZE, DEF_IFM_DEPTH, DEF_NUM_UNITS);
    localparam int COL_W           = cnt_width(DEF_IFM_SIZE);
    localparam int ROW_PAIR_W      = cnt_width(ROW_PAIRS);
    localparam int GROUP_W         = cnt_width(GROUPS);

endpackage

// File: rtl/poolb_ctrl_u3_if.sv
// poolb_ctrl_u3_if
// Handshake and status bundle between the pooling controller and its
// surroundings (upstream beat source, datapath, layer scheduler).
// Signals:
//   start, data_valid             - driven by the master side (scheduler/upstream)
//   ready, fifo_enable,
//   pool_enable, out_valid,
//   col_idx, row_pair_idx,
//   group_idx, busy, done         - driven by the controller (slave side)
// Modports: master (scheduler/upstream view), slave (controller view).
interface poolb_ctrl_u3_if #(
    parameter int IFM_SIZE  = 10,
    parameter int IFM_DEPTH = 30,
    parameter int NUM_UNITS = 3
);
    import poolb_ctrl_u3_pkg::*;

    localparam int CW  = cnt_width(IFM_SIZE);
    localparam int RPW = cnt_width(row_pairs(IFM_SIZE));
    localparam int GW  = cnt_width(groups(IFM_DEPTH, NUM_UNITS));

    logic          start;
    logic          data_valid;
    logic          ready;
    logic          fifo_enable;
    logic          pool_enable;
    logic          out_valid;
    logic [CW-1:0]  col_idx;
    logic [RPW-1:0] row_pair_idx;
    logic [GW-1:0]  group_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, data_valid,
        input  ready, fifo_enable, pool_enable, out_valid,
               col_idx, row_pair_idx, group_idx, busy, done
    );

    modport slave (
        input  start, data_valid,
        output ready, fifo_enable, pool_enable, out_valid,
               col_idx, row_pair_idx, group_idx, busy, done
    );

endinterface

// File: rtl/poolb_valid_delay.sv
// poolb_valid_delay
// Fixed-latency shift register for a single valid strobe.
// Ports:
//   clk   in  clock
//   clear in  synchronous clear of every stage (discards in-flight strobes)
//   din   in  strobe entering the line
//   dout  out strobe delayed by LATENCY cycles
module poolb_valid_delay #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic din,
    output logic dout
);
    logic [LATENCY-1:0] taps;

    // Shift-and-insert form stays legal for LATENCY == 1.
    always_ff @(posedge clk) begin
        if (clear) begin
            taps <= '0;
        end else begin
            taps <= (taps << 1) | LATENCY'(din);
        end
    end

    assign dout = taps[LATENCY-1];

endmodule

// File: rtl/poolb_ctrl_u3.sv
// poolb_ctrl_u3
// Sequencer for the three-unit 2x2 max/avg pooling datapath. Accepts one
// row-pair column beat per cycle while in RUN, walks column / row-pair /
// channel-group counters, gates the datapath enables, flags valid pooled
// outputs after POOL_LATENCY cycles and pulses done at layer end.
// Ports:
//   clk    in  clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of poolb_ctrl_u3_if (start, data_valid in;
//          ready, fifo_enable, pool_enable, out_valid, col_idx,
//          row_pair_idx, group_idx, busy, done out)
module poolb_ctrl_u3
    import poolb_ctrl_u3_pkg::*;
#(
    parameter int IFM_SIZE     = DEF_IFM_SIZE,
    parameter int IFM_DEPTH    = DEF_IFM_DEPTH,
    parameter int NUM_UNITS    = DEF_NUM_UNITS,
    parameter int KERNAL_SIZE  = DEF_KERNAL_SIZE,
    parameter int POOL_LATENCY = DEF_POOL_LATENCY
) (
    input logic          clk,
    input logic          reset,
    poolb_ctrl_u3_if.slave bus
);
    localparam int N_ROW_PAIRS = row_pairs(IFM_SIZE);
    localparam int N_GROUPS    = groups(IFM_DEPTH, NUM_UNITS);
    localparam int CW          = cnt_width(IFM_SIZE);
    localparam int RPW         = cnt_width(N_ROW_PAIRS);
    localparam int GW          = cnt_width(N_GROUPS);
    localparam int DW          = cnt_width(POOL_LATENCY);

    if (IFM_SIZE % 2 != 0) begin : g_bad_ifm_size
        $error("poolb_ctrl_u3: IFM_SIZE must be even");
    end
    if (IFM_DEPTH % NUM_UNITS != 0) begin : g_bad_ifm_depth
        $error("poolb_ctrl_u3: IFM_DEPTH must be divisible by NUM_UNITS");
    end
    if (KERNAL_SIZE != 2) begin : g_bad_kernel
        $error("poolb_ctrl_u3: only KERNAL_SIZE 2 is supported");
    end
    if (POOL_LATENCY < 1 || POOL_LATENCY > 4) begin : g_bad_latency
        $error("poolb_ctrl_u3: POOL_LATENCY must be in 1..4");
    end

    pool_state_t    state, state_next;
    logic [CW-1:0]  col_idx;
    logic [RPW-1:0] row_pair_idx;
    logic [GW-1:0]  group_idx;
    logic [DW-1:0]  drain_cnt;
    logic           accept;
    logic           col_last;
    logic           row_pair_last;
    logic           group_last;
    logic           layer_last;
    logic           pool_en;
    logic           out_valid;

    // The pooling window closes on odd columns, so only those beats pool.
    always_comb begin
        accept        = (state == RUN) && bus.data_valid;
        col_last      = (col_idx == CW'(IFM_SIZE - 1));
        row_pair_last = (row_pair_idx == RPW'(N_ROW_PAIRS - 1));
        group_last    = (group_idx == GW'(N_GROUPS - 1));
        layer_last    = accept && col_last && row_pair_last && group_last;
        pool_en       = accept && col_idx[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (layer_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Nested wrap: every counter naturally returns to 0 on the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_idx      <= '0;
            row_pair_idx <= '0;
            group_idx    <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_idx <= '0;
                if (row_pair_last) begin
                    row_pair_idx <= '0;
                    if (group_last) begin
                        group_idx <= '0;
                    end else begin
                        group_idx <= group_idx + GW'(1);
                    end
                end else begin
                    row_pair_idx <= row_pair_idx + RPW'(1);
                end
            end else begin
                col_idx <= col_idx + CW'(1);
            end
        end
    end

    // Loaded with LATENCY-1 so DRAIN spans exactly POOL_LATENCY cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (layer_last) begin
            drain_cnt <= DW'(POOL_LATENCY - 1);
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DW'(1);
        end
    end

    poolb_valid_delay #(
        .LATENCY (POOL_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .clear (reset),
        .din   (pool_en),
        .dout  (out_valid)
    );

    assign bus.ready        = (state == RUN);
    assign bus.fifo_enable  = accept;
    assign bus.pool_enable  = pool_en;
    assign bus.out_valid    = out_valid;
    assign bus.col_idx      = col_idx;
    assign bus.row_pair_idx = row_pair_idx;
    assign bus.group_idx    = group_idx;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_poolb_ctrl_u3.sv
// tb_poolb_ctrl_u3
// Bench for poolb_ctrl_u3. Instance a uses the default geometry
// (10x10x30, latency 1); instance b uses IFM_SIZE 4, IFM_DEPTH 6, latency 3.
module tb_poolb_ctrl_u3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    poolb_ctrl_u3_if #(.IFM_SIZE(10), .IFM_DEPTH(30), .NUM_UNITS(3)) a_if ();
    poolb_ctrl_u3_if #(.IFM_SIZE(4), .IFM_DEPTH(6), .NUM_UNITS(3)) b_if ();

    poolb_ctrl_u3 #(
        .IFM_SIZE(10), .IFM_DEPTH(30), .NUM_UNITS(3), .KERNAL_SIZE(2), .POOL_LATENCY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );

    poolb_ctrl_u3 #(
        .IFM_SIZE(4), .IFM_DEPTH(6), .NUM_UNITS(3), .KERNAL_SIZE(2), .POOL_LATENCY(3)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Per-instance observation counters, cleared by the scenarios.
    int a_beat, a_fifo, a_pool, a_ov, a_run, a_drain, a_done, a_idx_bad, a_odd_bad, a_lat_bad;
    int a_first_fifo, a_first_pool, a_last_ov, a_done_cyc;
    int a_pq[$];
    int b_beat, b_fifo, b_pool, b_ov, b_drain, b_done, b_idx_bad, b_odd_bad, b_lat_bad;
    int b_last_ov, b_done_cyc;
    int b_pq[$];

    // Beat-order model: beat n must present col n%S, row pair (n/S)%(S/2), group n/(S*S/2).
    always @(negedge clk) begin
        int t;
        if (a_if.fifo_enable) begin
            if (a_if.col_idx !== 4'(a_beat % 10) || a_if.row_pair_idx !== 3'((a_beat / 10) % 5)
                || a_if.group_idx !== 4'(a_beat / 50)) a_idx_bad++;
            if (a_fifo == 0) a_first_fifo = cyc;
            a_beat++;
            a_fifo++;
        end
        if (a_if.pool_enable) begin
            if (a_pool == 0) a_first_pool = cyc;
            if (a_if.col_idx[0] !== 1'b1) a_odd_bad++;
            a_pq.push_back(cyc);
            a_pool++;
        end
        if (a_if.out_valid) begin
            a_ov++;
            a_last_ov = cyc;
            if (a_pq.size() == 0) a_lat_bad++;
            else begin
                t = a_pq.pop_front();
                if (cyc - t != 1) a_lat_bad++;
            end
        end
        if (a_if.ready) a_run++;
        if (a_if.busy && !a_if.ready && !a_if.done) a_drain++;
        if (a_if.done) begin
            a_done++;
            a_done_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        int t;
        if (b_if.fifo_enable) begin
            if (b_if.col_idx !== 2'(b_beat % 4) || b_if.row_pair_idx !== 1'((b_beat / 4) % 2)
                || b_if.group_idx !== 1'(b_beat / 8)) b_idx_bad++;
            b_beat++;
            b_fifo++;
        end
        if (b_if.pool_enable) begin
            if (b_if.col_idx[0] !== 1'b1) b_odd_bad++;
            b_pq.push_back(cyc);
            b_pool++;
        end
        if (b_if.out_valid) begin
            b_ov++;
            b_last_ov = cyc;
            if (b_pq.size() == 0) b_lat_bad++;
            else begin
                t = b_pq.pop_front();
                if (cyc - t != 3) b_lat_bad++;
            end
        end
        if (b_if.busy && !b_if.ready && !b_if.done) b_drain++;
        if (b_if.done) begin
            b_done++;
            b_done_cyc = cyc;
        end
    end

    task automatic clear_a();
        a_beat = 0; a_fifo = 0; a_pool = 0; a_ov = 0; a_run = 0; a_drain = 0; a_done = 0;
        a_idx_bad = 0; a_odd_bad = 0; a_lat_bad = 0;
        a_first_fifo = -1; a_first_pool = -1; a_last_ov = -1; a_done_cyc = -1;
        a_pq.delete();
    endtask

    task automatic clear_b();
        b_beat = 0; b_fifo = 0; b_pool = 0; b_ov = 0; b_drain = 0; b_done = 0;
        b_idx_bad = 0; b_odd_bad = 0; b_lat_bad = 0; b_last_ov = -1; b_done_cyc = -1;
        b_pq.delete();
    endtask

    // Drives instance a through the IDLE start cycle.
    task automatic start_a();
        @(posedge clk); #1;
        a_if.start = 1'b1;
        a_if.data_valid = 1'b0;
    endtask

    // Runs beats until done is seen; returns in the DONE cycle.
    task automatic run_layer_a(input bit toggle, input bit start_mid, input bit start_at_done);
        bit timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            a_if.data_valid = toggle ? (i % 2 == 0) : 1'b1;
            a_if.start = start_mid && (i == 100);
            #1;
            if (a_if.done) begin
                a_if.start = start_at_done;
                timed_out = 1'b0;
                break;
            end
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("[TB] FAIL layer_a_timeout got no done want done within 3000 cycles");
        end
    endtask

    // Leaves DONE and settles on the first IDLE cycle after the monitor has seen DONE.
    task automatic finish_a();
        @(posedge clk); #1;
        a_if.start = 1'b0;
        a_if.data_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        a_if.start = 1'b0; a_if.data_valid = 1'b0;
        b_if.start = 1'b0; b_if.data_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_if.start = 1'b1; a_if.data_valid = 1'b1;
        b_if.start = 1'b1; b_if.data_valid = 1'b1;
        @(posedge clk); #2;
        checks++; if (a_if.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", a_if.ready); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", a_if.busy); end
        checks++; if (a_if.fifo_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo got %b want 0", a_if.fifo_enable); end
        checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ov got %b want 0", a_if.out_valid); end
        checks++; if (a_if.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", a_if.done); end
        checks++; if ({a_if.col_idx, a_if.row_pair_idx, a_if.group_idx} !== 11'd0) begin
            errors++; $display("[TB] FAIL reset_counters got %0d/%0d/%0d want 0/0/0",
                               a_if.col_idx, a_if.row_pair_idx, a_if.group_idx); end
        checks++; if (b_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_busy got %b want 0", b_if.busy); end
        reset = 1'b0;
        a_if.start = 1'b0; a_if.data_valid = 1'b0;
        b_if.start = 1'b0; b_if.data_valid = 1'b0;
    endtask

    task automatic test_full_layer();
        clear_a();
        start_a();
        run_layer_a(1'b0, 1'b0, 1'b0);
        finish_a();
        checks++; if (a_fifo !== 500) begin errors++; $display("[TB] FAIL full_fifo got %0d want 500", a_fifo); end
        checks++; if (a_pool !== 250) begin errors++; $display("[TB] FAIL full_pool got %0d want 250", a_pool); end
        checks++; if (a_ov !== 250) begin errors++; $display("[TB] FAIL full_ov got %0d want 250", a_ov); end
        checks++; if (a_idx_bad !== 0) begin errors++; $display("[TB] FAIL full_index_order got %0d bad want 0", a_idx_bad); end
        checks++; if (a_odd_bad !== 0) begin errors++; $display("[TB] FAIL full_pool_odd got %0d bad want 0", a_odd_bad); end
        checks++; if (a_lat_bad !== 0) begin errors++; $display("[TB] FAIL full_ov_latency got %0d bad want 0", a_lat_bad); end
        checks++; if (a_first_pool !== a_first_fifo + 1) begin errors++;
            $display("[TB] FAIL full_first_pool got cycle %0d want %0d", a_first_pool, a_first_fifo + 1); end
        checks++; if (a_run !== 500) begin errors++; $display("[TB] FAIL full_run_cycles got %0d want 500", a_run); end
        checks++; if (a_drain !== 1) begin errors++; $display("[TB] FAIL full_drain got %0d want 1", a_drain); end
        checks++; if (a_done !== 1 || a_done_cyc !== a_last_ov + 1) begin errors++;
            $display("[TB] FAIL full_done got %0d pulses at %0d want 1 at %0d", a_done, a_done_cyc, a_last_ov + 1); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after got %b want 0", a_if.busy); end
    endtask

    task automatic test_toggle();
        clear_a();
        start_a();
        run_layer_a(1'b1, 1'b0, 1'b0);
        finish_a();
        checks++; if (a_fifo !== 500 || a_pool !== 250 || a_ov !== 250) begin errors++;
            $display("[TB] FAIL toggle_totals got %0d/%0d/%0d want 500/250/250", a_fifo, a_pool, a_ov); end
        checks++; if (a_idx_bad !== 0 || a_odd_bad !== 0) begin errors++;
            $display("[TB] FAIL toggle_order got %0d/%0d bad want 0/0", a_idx_bad, a_odd_bad); end
        checks++; if (a_run !== 999) begin errors++; $display("[TB] FAIL toggle_run_cycles got %0d want 999", a_run); end
    endtask

    task automatic test_start_ignored();
        clear_a();
        start_a();
        run_layer_a(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++; if (a_fifo !== 500 || a_idx_bad !== 0) begin errors++;
            $display("[TB] FAIL start_mid_totals got %0d beats %0d bad want 500 0", a_fifo, a_idx_bad); end
        checks++; if (a_if.ready !== 1'b0 || a_if.busy !== 1'b0) begin errors++;
            $display("[TB] FAIL start_in_done got ready %b busy %b want 0 0", a_if.ready, a_if.busy); end
        clear_a();
        a_if.start = 1'b1;
        a_if.data_valid = 1'b0;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        #1;
        checks++; if (a_if.ready !== 1'b1 || a_if.col_idx !== 4'd0 || a_if.group_idx !== 4'd0) begin errors++;
            $display("[TB] FAIL start_first_idle got ready %b col %0d grp %0d want 1 0 0",
                     a_if.ready, a_if.col_idx, a_if.group_idx); end
        run_layer_a(1'b0, 1'b0, 1'b0);
        finish_a();
        checks++; if (a_fifo !== 500 || a_ov !== 250 || a_done !== 1) begin errors++;
            $display("[TB] FAIL start_second_layer got %0d/%0d/%0d want 500/250/1", a_fifo, a_ov, a_done); end
    endtask

    task automatic test_reset_mid();
        clear_a();
        start_a();
        for (int i = 0; i < 137; i++) begin
            @(posedge clk); #1;
            a_if.start = 1'b0;
            a_if.data_valid = 1'b1;
        end
        @(posedge clk); #2;
        checks++; if (a_if.col_idx !== 4'd7 || a_if.row_pair_idx !== 3'd3 || a_if.group_idx !== 4'd2) begin
            errors++; $display("[TB] FAIL mid_beat137 got %0d/%0d/%0d want 7/3/2",
                               a_if.col_idx, a_if.row_pair_idx, a_if.group_idx); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        a_if.data_valid = 1'b0;
        #1;
        checks++; if (a_if.ready !== 1'b0 || a_if.busy !== 1'b0 || a_if.out_valid !== 1'b0 || a_if.done !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_after_reset got rdy %b busy %b ov %b done %b want 0 0 0 0",
                                     a_if.ready, a_if.busy, a_if.out_valid, a_if.done); end
        checks++; if ({a_if.col_idx, a_if.row_pair_idx, a_if.group_idx} !== 11'd0) begin errors++;
            $display("[TB] FAIL mid_counters got %0d/%0d/%0d want 0/0/0",
                     a_if.col_idx, a_if.row_pair_idx, a_if.group_idx); end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (a_done !== 0) begin errors++; $display("[TB] FAIL mid_no_done got %0d want 0", a_done); end
        clear_a();
        start_a();
        run_layer_a(1'b0, 1'b0, 1'b0);
        finish_a();
        checks++; if (a_fifo !== 500 || a_pool !== 250 || a_ov !== 250) begin errors++;
            $display("[TB] FAIL mid_restart got %0d/%0d/%0d want 500/250/250", a_fifo, a_pool, a_ov); end
    endtask

    task automatic test_latency3();
        bit timed_out;
        clear_b();
        @(posedge clk); #1;
        b_if.start = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            b_if.start = 1'b0;
            b_if.data_valid = 1'b1;
            #1;
            if (b_if.done) begin
                timed_out = 1'b0;
                break;
            end
        end
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL b_timeout got no done want done within 200 cycles"); end
        @(posedge clk); #1;
        b_if.data_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (b_fifo !== 16) begin errors++; $display("[TB] FAIL b_fifo got %0d want 16", b_fifo); end
        checks++; if (b_pool !== 8 || b_ov !== 8) begin errors++;
            $display("[TB] FAIL b_pool_ov got %0d/%0d want 8/8", b_pool, b_ov); end
        checks++; if (b_idx_bad !== 0 || b_odd_bad !== 0) begin errors++;
            $display("[TB] FAIL b_order got %0d/%0d bad want 0/0", b_idx_bad, b_odd_bad); end
        checks++; if (b_lat_bad !== 0) begin errors++; $display("[TB] FAIL b_latency got %0d bad want 0", b_lat_bad); end
        checks++; if (b_drain !== 3) begin errors++; $display("[TB] FAIL b_drain got %0d want 3", b_drain); end
        checks++; if (b_done !== 1 || b_done_cyc !== b_last_ov + 1) begin errors++;
            $display("[TB] FAIL b_done got %0d pulses at %0d want 1 at %0d", b_done, b_done_cyc, b_last_ov + 1); end
        checks++; if (b_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL b_busy_after got %b want 0", b_if.busy); end
    endtask

    initial begin
        clear_a();
        clear_b();
        test_reset();
        test_full_layer();
        test_toggle();
        test_start_ignored();
        test_reset_mid();
        test_latency3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
